// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer: state encoding and
// the bit-counter width helper.
package serial_add_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Counter must be able to hold the value WIDTH.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/ha.sv
// 1-bit half adder: the existing datapath primitive.
module ha (
   input  logic a_i,
   input  logic b_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i;
   assign c_o = a_i & b_i;

endmodule

// File: rtl/ha_full_slice.sv
// Combinational full-adder slice built from two half adders and an OR gate.
module ha_full_slice (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic s_o,
   output logic cout_o
);

   logic s0;
   logic c1;
   logic c2;

   ha u_ha0 (
      .a_i (a_i),
      .b_i (b_i),
      .s_o (s0),
      .c_o (c1)
   );

   ha u_ha1 (
      .a_i (s0),
      .b_i (cin_i),
      .s_o (s_o),
      .c_o (c2)
   );

   assign cout_o = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer (LSB first) with start/busy/done handshake.
// Optional subtraction is built only when SERIAL_ADD_SUB_EN is defined.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             done_q, done_d;

   logic slice_s;
   logic slice_c;

   ha_full_slice u_slice (
      .a_i    (a_q[0]),
      .b_i    (b_q[0]),
      .cin_i  (carry_q),
      .s_o    (slice_s),
      .cout_o (slice_c)
   );

`ifndef SERIAL_ADD_SUB_EN
   logic unused_sub;
   assign unused_sub = sub;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = op_a;
               b_d     = op_b;
               carry_d = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
               // Two's complement: a + ~b + 1.
               if (sub) begin
                  b_d     = ~op_b;
                  carry_d = 1'b1;
               end
`endif
               cnt_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = {slice_s, sum_q[WIDTH-1:1]};
            carry_d = slice_c;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               cout_d  = slice_c;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ena low freezes every register, which also stretches a pending done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (ena) begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: table vectors, multi-cycle corner sequences and
// randomized operations against a plain-arithmetic reference model.
module tb_serial_add_ctrl;

   localparam int W = 4;
`ifdef SERIAL_ADD_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   logic         clk;
   logic         rst_n;
   logic         ena;
   logic         start;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         sub;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int n_tests;
   int n_fail;

   logic [W:0] exp_q[$];

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      logic [W-1:0] es;
      logic         ec;
   } vec_t;

   vec_t vecs[7];

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .start (start),
      .op_a  (op_a),
      .op_b  (op_b),
      .sub   (sub),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic, {cout, sum}.
   function automatic logic [W:0] model(input int a, input int b, input bit s);
      int r;
      if (SUB_EN && s) r = a + ((1 << W) - 1 - b) + 1;
      else             r = a + b;
      return r[W:0];
   endfunction

   // Issue one start and wait for done; lat = edges from accept to done.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W-1:0] rs, output logic rc, output int lat);
      @(negedge clk);
      op_a = a; op_b = b; sub = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      while (!done && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      rs = sum;
      rc = cout;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic scoreboard_check(input string name, input logic [W-1:0] rs, input logic rc);
      logic [W:0] e;
      if (exp_q.size() == 0) begin
         check({name, "_empty_q"}, 1, 0);
      end else begin
         e = exp_q.pop_front();
         check({name, "_sum"}, int'(rs), int'(e[W-1:0]));
         check({name, "_cout"}, int'(rc), int'(e[W]));
      end
   endtask

   initial begin : main
      logic [W-1:0] rs;
      logic         rc;
      logic [W-1:0] snap;
      int           lat;
      int           seen;
      n_tests = 0;
      n_fail  = 0;

      vecs[0] = '{a: 4'd3,  b: 4'd5, s: 1'b0, es: 4'd8,  ec: 1'b0};
      vecs[1] = '{a: 4'd15, b: 4'd1, s: 1'b0, es: 4'd0,  ec: 1'b1};
      vecs[2] = '{a: 4'd0,  b: 4'd0, s: 1'b0, es: 4'd0,  ec: 1'b0};
      vecs[3] = '{a: 4'd6,  b: 4'd7, s: 1'b0, es: 4'd13, ec: 1'b0};
      vecs[4] = '{a: 4'd9,  b: 4'd9, s: 1'b0, es: 4'd2,  ec: 1'b1};
`ifdef SERIAL_ADD_SUB_EN
      vecs[5] = '{a: 4'd5,  b: 4'd3, s: 1'b1, es: 4'd2,  ec: 1'b1};
      vecs[6] = '{a: 4'd3,  b: 4'd5, s: 1'b1, es: 4'd14, ec: 1'b0};
`else
      vecs[5] = '{a: 4'd5,  b: 4'd3, s: 1'b1, es: 4'd8,  ec: 1'b0};
      vecs[6] = '{a: 4'd3,  b: 4'd5, s: 1'b1, es: 4'd8,  ec: 1'b0};
`endif

      rst_n = 1'b0; ena = 1'b1; start = 1'b0; op_a = '0; op_b = '0; sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_sum", int'(sum), 0);
      check("reset_cout", int'(cout), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // table-driven vectors
      for (int i = 0; i < 7; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].s, rs, rc, lat);
         check($sformatf("vec%0d_lat", i), lat, W);
         check($sformatf("vec%0d_busy_at_done", i), int'(busy), 1);
         check($sformatf("vec%0d_sum", i), int'(rs), int'(vecs[i].es));
         check($sformatf("vec%0d_cout", i), int'(rc), int'(vecs[i].ec));
         @(posedge clk); #1;
         check($sformatf("vec%0d_done_drop", i), int'(done), 0);
         check($sformatf("vec%0d_idle", i), int'(busy), 0);
      end

      // back-to-back: start held high, second op accepted right after IDLE
      @(negedge clk);
      op_a = 4'd15; op_b = 4'd1; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      wait_done(lat);
      check("b2b_first_lat", lat, W);
      check("b2b_first_sum", int'(sum), 0);
      check("b2b_first_cout", int'(cout), 1);
      op_a = 4'd0; op_b = 4'd0;
      @(posedge clk); #1;
      check("b2b_idle_gap", int'(busy), 0);
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_second_accept", int'(busy), 1);
      check("b2b_cleared_cout", int'(cout), 0);
      wait_done(lat);
      check("b2b_second_lat", lat, W);
      check("b2b_second_sum", int'(sum), 0);
      check("b2b_second_cout", int'(cout), 0);
      @(posedge clk); #1;

      // start during SHIFT is ignored
      @(negedge clk);
      op_a = 4'd3; op_b = 4'd5; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      op_a = 4'd15; op_b = 4'd15; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 3;
      while (!done && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check("ign_lat", lat, W);
      check("ign_sum", int'(sum), 8);
      check("ign_cout", int'(cout), 0);
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done || busy) seen++;
      end
      check("ign_no_second_op", seen, 0);

      // reset mid-operation aborts
      @(negedge clk);
      op_a = 4'd3; op_b = 4'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", int'(busy), 0);
      check("rst_mid_sum", int'(sum), 0);
      check("rst_mid_cout", int'(cout), 0);
      check("rst_mid_done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      check("rst_mid_no_done", seen, 0);
      do_op(4'd6, 4'd7, 1'b0, rs, rc, lat);
      check("rst_after_sum", int'(rs), 13);
      check("rst_after_cout", int'(rc), 0);
      @(posedge clk); #1;

      // ena low mid-SHIFT for 3 cycles
      @(negedge clk);
      op_a = 4'd9; op_b = 4'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      ena = 1'b0;
      snap = sum;
      repeat (3) @(posedge clk);
      #1;
      check("ena_frozen_sum", int'(sum), int'(snap));
      check("ena_frozen_busy", int'(busy), 1);
      @(negedge clk);
      ena = 1'b1;
      wait_done(lat);
      check("ena_remaining_lat", lat, 2);
      check("ena_sum", int'(sum), 2);
      check("ena_cout", int'(cout), 1);
      // done pulse stretched while ena low
      @(negedge clk);
      ena = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("ena_done_stretch", int'(done), 1);
      @(negedge clk);
      ena = 1'b1;
      @(posedge clk); #1;
      check("ena_done_release", int'(done), 0);
      @(posedge clk); #1;

      // randomized operations against the reference model
      for (int i = 0; i < 30; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic         rsub;
         ra   = W'($urandom_range(0, (1 << W) - 1));
         rb   = W'($urandom_range(0, (1 << W) - 1));
         rsub = 1'($urandom_range(0, 1));
         exp_q.push_back(model(int'(ra), int'(rb), rsub));
         do_op(ra, rb, rsub, rs, rc, lat);
         check($sformatf("rnd%0d_lat", i), lat, W);
         scoreboard_check($sformatf("rnd%0d", i), rs, rc);
         @(posedge clk); #1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
